// File: rtl/pc_pkg.sv
// Shared types and defaults for the FEG fetch-stage program-counter sequencer.
package pc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} pc_state_t;
    localparam int PC_W          = 12;
    localparam int STK_DEPTH_DEF = 4;
endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: a register array addressed by its occupancy count.
// The top entry is read combinationally.
module ret_stack import pc_pkg::*; #(
    parameter int W     = PC_W,
    parameter int DEPTH = STK_DEPTH_DEF
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW:0]   cnt_q, cnt_d;
    logic [PW:0]   cnt_dec;
    logic [PW-1:0] top_idx, wr_idx;

    // The count doubles as the write pointer; the top entry sits one below it.
    assign cnt_dec = cnt_q - 1'b1;
    assign top_idx = cnt_dec[PW-1:0];
    assign wr_idx  = cnt_q[PW-1:0];
    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[top_idx];

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (push && !full)
            cnt_d = cnt_q + 1'b1;
        else if (pop && !empty)
            cnt_d = cnt_dec;
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    always_ff @(posedge Clk) begin
        if (!Reset && !clear && push && !full)
            mem_q[wr_idx] <= din;
    end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: run/halt FSM, prioritised next-PC selection,
// return-address stack and a sticky stack error flag.
module pc_sequencer import pc_pkg::*; #(
    parameter int D         = PC_W,
    parameter int STK_DEPTH = STK_DEPTH_DEF
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         halt,
    input  logic         jmp,
    input  logic         br_en,
    input  logic         br_cond,
    input  logic         call,
    input  logic         ret,
    input  logic [D-1:0] target,
    output logic [D-1:0] pc,
    output logic         done,
    output logic         stk_err
);
    pc_state_t    state_q, state_d;
    logic [D-1:0] pc_q, pc_d, pc_inc, stk_top;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         push, pop, clear, full, empty;

    assign pc_inc = pc_q + D'(1);

    ret_stack #(.W(D), .DEPTH(STK_DEPTH)) u_stack (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (pc_inc),
        .dout  (stk_top),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (Start) state_d = RUN;
            end
            RUN: begin
                // One action per cycle; earlier branches win.
                if (halt) begin
                    state_d = HALTED;
                end else if (ret) begin
                    if (!empty) begin
                        pc_d = stk_top;
                        pop  = 1'b1;
                    end else begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end
                end else if (call) begin
                    pc_d = target;
                    if (!full) push = 1'b1;
                    else       err_d = 1'b1;
                end else if (jmp || (br_en && br_cond)) begin
                    pc_d = target;
                end else begin
                    pc_d = pc_inc;
                end
            end
            HALTED: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    clear   = 1'b1;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == HALTED);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign pc      = pc_q;
    assign done    = done_q;
    assign stk_err = err_q;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the FEG processor fetch stage. Holds the 12-bit PC and selects each cycle's next PC: increment, unconditional jump, conditional branch, call, or return. Branch and jump destinations arrive on `target` from the branch-target lookup table, which is indexed by the instruction's 5-bit field. Also holds a small return-address stack and the run/halt state that drives `done`.

## Interface
- `D`, 12, PC width; must equal the lookup-table target width
- `STK_DEPTH`, 4, return-stack entries (power of two, ≥2)
- `Clk` input 1: single clock, rising-edge
- `Reset` input 1: synchronous, active-high
- `Start` input 1: run request; sampled at the clock edge
- `halt` input 1: decoded halt instruction
- `jmp` input 1: unconditional jump to `target`
- `br_en` input 1: conditional branch instruction
- `br_cond` input 1: branch condition flag from ALU
- `call` input 1: push return address, jump to `target`
- `ret` input 1: pop return address into PC
- `target` input D: destination from the lookup table (combinational, same cycle)
- `pc` output D: current instruction address
- `done` output 1: program halted
- `stk_err` output 1: sticky stack overflow/underflow flag

## Operation
- States: IDLE, RUN, HALTED.
- **IDLE:** `pc`=0 held.
  - `Start`=1 → RUN.
- **RUN:** exactly one action per cycle, chosen by this priority:
  - `halt`: pc holds; → HALTED.
  - `ret`: if the stack is non-empty, pc←top and pop. If empty, pc←pc+1 and set `stk_err`.
  - `call`: if the stack is not full, push pc+1 and pc←target. If full, no push, pc←target, set `stk_err`.
  - `jmp`: pc←target.
  - `br_en` with `br_cond`=1: pc←target.
  - Otherwise (including `br_en` with `br_cond`=0): pc←pc+1.
- **HALTED:** `done`=1; pc holds.
  - `Start`=1 → RUN with pc←0, stack emptied, `stk_err` cleared.
- All control inputs are ignored in IDLE and HALTED.
- `Start` is ignored in RUN.
- **Arithmetic:** pc+1 is modulo 2^D; 2^D−1 wraps to 0 with no flag. The pushed return address wraps the same way.
- **Stack:** LIFO with a pointer and occupancy count 0..STK_DEPTH.
  - Full means count = STK_DEPTH; empty means count = 0.
  - A call and a ret in the same cycle resolve by priority: only the ret executes.
- `stk_err` is sticky. It clears only on `Reset`, or on `Start` from HALTED.

## Timing
- Inputs are sampled on the rising edge of `Clk`; `pc`, `done`, `stk_err` and the state update at that edge.
- A redirect is visible on `pc` one cycle after the controlling instruction's cycle. There are no bubbles and no delay slots.
- `target` must be stable before the edge in any cycle where `jmp`, `call` or a taken branch is asserted.
- **Reset** (any state, mid-operation included), at the next edge:
  - state=IDLE, `pc`=0, `done`=0, `stk_err`=0, stack count=0.
  - `Reset` dominates `Start` and every control input.
- **Start latency:**
  - IDLE→RUN: 1 edge. The first RUN cycle fetches pc=0.
  - HALTED→RUN: 1 edge, with `done` low in the same cycle.
- `done` rises on the edge after `halt` is sampled in RUN. It then stays high until `Start` or `Reset`.

## Structure
- Shared package `pc_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, HALTED} pc_state_t;`
  - `localparam PC_W = 12`
  - `localparam STK_DEPTH_DEF = 4`
- Sub-module `ret_stack`:
  - Ports: push, pop, din, dout, full, empty, clear; `Clk`, `Reset`.
  - Register array with a pointer; read is combinational from the top entry.
- `pc_sequencer` holds the FSM, the next-PC mux, priority decode and the error flag.
- Expected size: about 200 lines total.

## Test plan
- **Sequential run:** Reset, `Start` pulse, 5 idle cycles → pc 0,0,1,2,3,4. Then `halt` at pc=4 → pc stays 4, `done`=1 on the next cycle.
- **Branch:**
  - At pc=3, `br_en`=1, `br_cond`=0 → pc=4.
  - At pc=4, `br_en`=1, `br_cond`=1, target=117 → pc=117.
  - `jmp` with target=13 → pc=13.
- **Call/return:**
  - At pc=7, `call` with target=59 → pc=59.
  - At pc=59, `call` with target=132 → pc=132.
  - `ret` → pc=60; `ret` → pc=8.
  - `stk_err` stays 0 throughout.
- **Overflow/underflow:**
  - 5 calls with target=20 → 5th call jumps to 20 and `stk_err`=1. Afterwards, 4 rets return correctly.
  - 5th ret on an empty stack → pc+1, `stk_err` stays 1.
- **Wrap and priority:**
  - jmp to target=4095, next cycle → pc=0.
  - `halt`+`jmp` together → halted with pc unchanged.
  - `call`+`ret` together → ret only.
- **Reset mid-run:**
  - `Reset` while pc=117 with 2 stack entries → next edge: pc=0, IDLE, empty stack.
  - `Start`=1 together with `Reset` → IDLE.
